// File: rtl/axi4_stream_sparse_downsizer.sv
// AXI4-Stream width downsizer: one wide beat becomes up to RATIO narrow beats,
// and segments whose tkeep bits are all clear are skipped, wherever they sit in the beat.
module axi4_stream_sparse_downsizer #(
  parameter int SLAVE_TDATA_WIDTH  = 64,
  parameter int MASTER_TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH        = 1,
  parameter int TDEST_WIDTH        = 1,
  parameter int TID_WIDTH          = 1,
  parameter bit TUSER_FIRST_ONLY   = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [SLAVE_TDATA_WIDTH-1:0]    pkt_i_tdata,
  input  logic [SLAVE_TDATA_WIDTH/8-1:0]  pkt_i_tkeep,
  input  logic [SLAVE_TDATA_WIDTH/8-1:0]  pkt_i_tstrb,
  input  logic [TUSER_WIDTH-1:0]          pkt_i_tuser,
  input  logic [TDEST_WIDTH-1:0]          pkt_i_tdest,
  input  logic [TID_WIDTH-1:0]            pkt_i_tid,
  input  logic                            pkt_i_tlast,
  input  logic                            pkt_i_tvalid,
  output logic                            pkt_i_tready,
  output logic [MASTER_TDATA_WIDTH-1:0]   pkt_o_tdata,
  output logic [MASTER_TDATA_WIDTH/8-1:0] pkt_o_tkeep,
  output logic [MASTER_TDATA_WIDTH/8-1:0] pkt_o_tstrb,
  output logic [TUSER_WIDTH-1:0]          pkt_o_tuser,
  output logic [TDEST_WIDTH-1:0]          pkt_o_tdest,
  output logic [TID_WIDTH-1:0]            pkt_o_tid,
  output logic                            pkt_o_tlast,
  output logic                            pkt_o_tvalid,
  input  logic                            pkt_o_tready
);

  localparam int RATIO = SLAVE_TDATA_WIDTH / MASTER_TDATA_WIDTH;
  localparam int MB    = MASTER_TDATA_WIDTH / 8;
  localparam int SKW   = SLAVE_TDATA_WIDTH / 8;

  logic [SLAVE_TDATA_WIDTH-1:0] hold_data;
  logic [SKW-1:0]               hold_keep;
  logic [SKW-1:0]               hold_strb;
  logic [TUSER_WIDTH-1:0]       hold_user;
  logic [TDEST_WIDTH-1:0]       hold_dest;
  logic [TID_WIDTH-1:0]         hold_id;
  logic                         hold_last;
  logic [RATIO-1:0]             pend;
  logic                         busy;
  logic                         first_seg;
  logic                         rdy_en;

  logic [RATIO-1:0]             live;
  logic [RATIO-1:0]             sel;
  logic                         last_seg;
  logic                         rx;
  logic                         tx;

  always_comb begin
    live = '0;
    for (int k = 0; k < RATIO; k++) begin
      live[k] = |pkt_i_tkeep[k*MB +: MB];
    end
  end

  // sel is the one-hot lowest pending segment; an empty mask (null tlast beat) points at segment 0
  assign sel      = (pend == '0) ? RATIO'(1) : (pend & (~pend + RATIO'(1)));
  assign last_seg = (pend & (pend - RATIO'(1))) == '0;

  assign pkt_i_tready = rdy_en && (!busy || (pkt_o_tready && last_seg));
  assign rx           = pkt_i_tvalid && pkt_i_tready;
  assign tx           = busy && pkt_o_tready;

  always_comb begin
    pkt_o_tdata  = '0;
    pkt_o_tkeep  = '0;
    pkt_o_tstrb  = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (sel[k]) begin
        pkt_o_tdata = hold_data[k*MASTER_TDATA_WIDTH +: MASTER_TDATA_WIDTH];
        pkt_o_tkeep = hold_keep[k*MB +: MB];
        pkt_o_tstrb = hold_strb[k*MB +: MB];
      end
    end
    pkt_o_tvalid = busy;
    pkt_o_tlast  = busy && hold_last && last_seg;
    pkt_o_tuser  = (!TUSER_FIRST_ONLY || first_seg) ? hold_user : '0;
    pkt_o_tdest  = hold_dest;
    pkt_o_tid    = hold_id;
  end

  // A capture always wins over the final tx: tready only opens on the last segment, so they coincide
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_data <= '0;
      hold_keep <= '0;
      hold_strb <= '0;
      hold_user <= '0;
      hold_dest <= '0;
      hold_id   <= '0;
      hold_last <= 1'b0;
      pend      <= '0;
      busy      <= 1'b0;
      first_seg <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (rx) begin
        hold_data <= pkt_i_tdata;
        hold_keep <= pkt_i_tkeep;
        hold_strb <= pkt_i_tstrb;
        hold_user <= pkt_i_tuser;
        hold_dest <= pkt_i_tdest;
        hold_id   <= pkt_i_tid;
        hold_last <= pkt_i_tlast;
        pend      <= live;
        busy      <= (live != '0) || pkt_i_tlast;
        first_seg <= 1'b1;
      end else if (tx) begin
        first_seg <= 1'b0;
        if (last_seg) begin
          busy <= 1'b0;
          pend <= '0;
        end else begin
          pend <= pend & ~sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_sparse_downsizer.sv
// Directed bench for the sparse downsizer: 64->32 vector table plus multi-cycle sequences,
// and a 128->32 instance for the sparse mid-beat hole case.
module tb_axi4_stream_sparse_downsizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] i_tdata;
  logic [7:0]  i_tkeep, i_tstrb;
  logic        i_tuser, i_tdest, i_tid, i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep, o_tstrb;
  logic        o_tuser, o_tdest, o_tid, o_tlast, o_tvalid, o_tready;

  logic [127:0] w_i_tdata;
  logic [15:0]  w_i_tkeep, w_i_tstrb;
  logic         w_i_tuser, w_i_tdest, w_i_tid, w_i_tlast, w_i_tvalid, w_i_tready;
  logic [31:0]  w_o_tdata;
  logic [3:0]   w_o_tkeep, w_o_tstrb;
  logic         w_o_tuser, w_o_tdest, w_o_tid, w_o_tlast, w_o_tvalid, w_o_tready;

  axi4_stream_sparse_downsizer #(.SLAVE_TDATA_WIDTH(64), .MASTER_TDATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tdata(i_tdata), .pkt_i_tkeep(i_tkeep), .pkt_i_tstrb(i_tstrb), .pkt_i_tuser(i_tuser),
    .pkt_i_tdest(i_tdest), .pkt_i_tid(i_tid), .pkt_i_tlast(i_tlast), .pkt_i_tvalid(i_tvalid),
    .pkt_i_tready(i_tready),
    .pkt_o_tdata(o_tdata), .pkt_o_tkeep(o_tkeep), .pkt_o_tstrb(o_tstrb), .pkt_o_tuser(o_tuser),
    .pkt_o_tdest(o_tdest), .pkt_o_tid(o_tid), .pkt_o_tlast(o_tlast), .pkt_o_tvalid(o_tvalid),
    .pkt_o_tready(o_tready)
  );

  axi4_stream_sparse_downsizer #(.SLAVE_TDATA_WIDTH(128), .MASTER_TDATA_WIDTH(32)) dut_wide (
    .clk_i(clk), .rst_n_i(rst_n),
    .pkt_i_tdata(w_i_tdata), .pkt_i_tkeep(w_i_tkeep), .pkt_i_tstrb(w_i_tstrb), .pkt_i_tuser(w_i_tuser),
    .pkt_i_tdest(w_i_tdest), .pkt_i_tid(w_i_tid), .pkt_i_tlast(w_i_tlast), .pkt_i_tvalid(w_i_tvalid),
    .pkt_i_tready(w_i_tready),
    .pkt_o_tdata(w_o_tdata), .pkt_o_tkeep(w_o_tkeep), .pkt_o_tstrb(w_o_tstrb), .pkt_o_tuser(w_o_tuser),
    .pkt_o_tdest(w_o_tdest), .pkt_o_tid(w_o_tid), .pkt_o_tlast(w_o_tlast), .pkt_o_tvalid(w_o_tvalid),
    .pkt_o_tready(w_o_tready)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        user;
    logic        dest;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          nexp;
    logic [63:0] edata;
    logic [7:0]  ekeep;
    logic [1:0]  elast;
    logic [1:0]  euser;
  } vec_t;

  beat_t got[$];
  beat_t gotw[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  bp_en = 1'b0;
  logic  stall_prev = 1'b0;
  beat_t stall_beat;
  vec_t  vecs[6];
  logic  acc, done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output handshakes are logged at the negedge; inputs only change at posedge+1
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && o_tvalid) begin
        checkOutput("stable_data", 64'(o_tdata), 64'(stall_beat.data));
        checkOutput("stable_ctl", 64'({o_tkeep, o_tuser, o_tlast}),
                    64'({stall_beat.keep, stall_beat.user, stall_beat.last}));
      end
      stall_prev = o_tvalid && !o_tready;
      stall_beat = '{o_tdata, o_tkeep, o_tstrb, o_tuser, o_tdest, o_tlast, cyc};
      if (o_tvalid && o_tready)
        got.push_back('{o_tdata, o_tkeep, o_tstrb, o_tuser, o_tdest, o_tlast, cyc});
      if (w_o_tvalid && w_o_tready)
        gotw.push_back('{w_o_tdata, w_o_tkeep, w_o_tstrb, w_o_tuser, w_o_tdest, w_o_tlast, cyc});
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (bp_en) o_tready = ($urandom_range(0, 99) >= 30);
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic ok;
    logic rdy;
    ok = 1'b0;
    i_tdata = d; i_tkeep = k; i_tstrb = k; i_tlast = l; i_tuser = u; i_tvalid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      rdy = i_tready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    i_tvalid = 1'b0;
    if (!ok) checkOutput("rx_timeout", 64'(ok), 64'(1));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{64'h1111_2222_3333_4444, 8'hFF, 1'b1, 1'b0, 2, 64'h1111_2222_3333_4444, 8'hFF, 2'b10, 2'b00};
    vecs[1] = '{64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1, 1'b1, 1, 64'h0000_0000_CCCC_DDDD, 8'h0F, 2'b01, 2'b01};
    vecs[2] = '{64'h0102_0304_0506_0708, 8'hF0, 1'b0, 1'b1, 1, 64'h0000_0000_0102_0304, 8'h0F, 2'b00, 2'b01};
    vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, 8'h3C, 1'b1, 1'b1, 2, 64'hDEAD_BEEF_CAFE_F00D, 8'h3C, 2'b10, 2'b01};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 8'h00, 1'b0, 1'b1, 0, 64'h0, 8'h00, 2'b00, 2'b00};
    vecs[5] = '{64'h5555_6666_7777_8888, 8'h00, 1'b1, 1'b0, 1, 64'h0000_0000_7777_8888, 8'h00, 2'b01, 2'b00};

    i_tdata = 64'hFFFF_FFFF_FFFF_FFFF; i_tkeep = 8'hFF; i_tstrb = 8'hFF; i_tuser = 1'b1;
    i_tdest = 1'b1; i_tid = 1'b0; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b1;
    w_i_tdata = '0; w_i_tkeep = '0; w_i_tstrb = '0; w_i_tuser = 1'b0; w_i_tdest = 1'b0;
    w_i_tid = 1'b0; w_i_tlast = 1'b0; w_i_tvalid = 1'b0; w_o_tready = 1'b1;

    $display("[TB] reset with upstream valid");
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_tready", 64'(i_tready), 64'(0));
    end
    checkOutput("rst_tvalid", 64'(o_tvalid), 64'(0));
    checkOutput("rst_tlast", 64'(o_tlast), 64'(0));
    checkOutput("rst_tdata", 64'({o_tdata, o_tkeep, o_tstrb, o_tuser}), 64'(0));
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rel_tready", 64'(i_tready), 64'(1));
    checkOutput("rel_tvalid", 64'(o_tvalid), 64'(0));
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      got.delete();
      applyStimulus(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user);
      waitCycles(4);
      checkOutput($sformatf("vec%0d_count", i), 64'(got.size()), 64'(vecs[i].nexp));
      for (int j = 0; j < vecs[i].nexp; j++) begin
        if (j < got.size()) begin
          checkOutput($sformatf("vec%0d_data%0d", i, j), 64'(got[j].data), 64'(vecs[i].edata[j*32 +: 32]));
          checkOutput($sformatf("vec%0d_keep%0d", i, j), 64'(got[j].keep), 64'(vecs[i].ekeep[j*4 +: 4]));
          checkOutput($sformatf("vec%0d_strb%0d", i, j), 64'(got[j].strb), 64'(vecs[i].ekeep[j*4 +: 4]));
          checkOutput($sformatf("vec%0d_last%0d", i, j), 64'(got[j].last), 64'(vecs[i].elast[j]));
          checkOutput($sformatf("vec%0d_user%0d", i, j), 64'(got[j].user), 64'(vecs[i].euser[j]));
          checkOutput($sformatf("vec%0d_dest%0d", i, j), 64'(got[j].dest), 64'(1));
        end
      end
    end

    $display("[TB] back-to-back full beats");
    got.delete();
    for (int b = 0; b < 4; b++) begin
      applyStimulus({32'hA500_0000 | 32'(2*b+1), 32'hA500_0000 | 32'(2*b)}, 8'hFF, (b == 3), 1'b0);
    end
    waitCycles(4);
    checkOutput("stream_count", 64'(got.size()), 64'(8));
    for (int j = 0; j < 8; j++) begin
      if (j < got.size()) begin
        checkOutput($sformatf("stream_data%0d", j), 64'(got[j].data), 64'(32'hA500_0000 | 32'(j)));
        checkOutput($sformatf("stream_cyc%0d", j), 64'(got[j].cyc - got[0].cyc), 64'(j));
        checkOutput($sformatf("stream_last%0d", j), 64'(got[j].last), 64'(j == 7));
      end
    end

    $display("[TB] 128->32 sparse keep");
    gotw.delete();
    w_i_tdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    w_i_tkeep = 16'hF0F0; w_i_tstrb = 16'hF0F0; w_i_tlast = 1'b1; w_i_tvalid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      acc = w_i_tready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    w_i_tvalid = 1'b0;
    checkOutput("wide_rx", 64'(done), 64'(1));
    waitCycles(6);
    checkOutput("wide_count", 64'(gotw.size()), 64'(2));
    if (gotw.size() == 2) begin
      checkOutput("wide_data0", 64'(gotw[0].data), 64'(32'h2222_2222));
      checkOutput("wide_last0", 64'(gotw[0].last), 64'(0));
      checkOutput("wide_data1", 64'(gotw[1].data), 64'(32'h4444_4444));
      checkOutput("wide_last1", 64'(gotw[1].last), 64'(1));
      checkOutput("wide_keep1", 64'(gotw[1].keep), 64'(4'hF));
    end

    $display("[TB] random backpressure");
    got.delete();
    bp_en = 1'b1;
    applyStimulus(64'h6000_0002_6000_0001, 8'hFF, 1'b0, 1'b1);
    applyStimulus(64'h6000_0003_0BAD_0BAD, 8'hF0, 1'b0, 1'b0);
    applyStimulus(64'h6000_0005_6000_0004, 8'hFF, 1'b1, 1'b0);
    for (int n = 0; n < 200 && got.size() < 5; n++) waitCycles(1);
    bp_en = 1'b0;
    waitCycles(1);
    o_tready = 1'b1;
    checkOutput("bp_count", 64'(got.size()), 64'(5));
    for (int j = 0; j < 5; j++) begin
      if (j < got.size()) begin
        checkOutput($sformatf("bp_data%0d", j), 64'(got[j].data), 64'(32'h6000_0001 + 32'(j)));
        checkOutput($sformatf("bp_user%0d", j), 64'(got[j].user), 64'(j == 0));
        checkOutput($sformatf("bp_last%0d", j), 64'(got[j].last), 64'(j == 4));
      end
    end

    $display("[TB] reset mid-beat");
    o_tready = 1'b0;
    applyStimulus(64'h7777_0002_7777_0001, 8'hFF, 1'b1, 1'b0);
    o_tready = 1'b1;
    @(posedge clk);
    #1;
    o_tready = 1'b0;
    @(negedge clk);
    checkOutput("mid_tvalid", 64'(o_tvalid), 64'(1));
    checkOutput("mid_data", 64'(o_tdata), 64'(32'h7777_0002));
    got.delete();
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("mid_rst_tvalid", 64'(o_tvalid), 64'(0));
    checkOutput("mid_rst_tready", 64'(i_tready), 64'(0));
    rst_n = 1'b1;
    o_tready = 1'b1;
    waitCycles(5);
    checkOutput("post_rst_quiet", 64'(got.size()), 64'(0));
    applyStimulus(64'h0000_0000_7777_0003, 8'h0F, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("post_rst_count", 64'(got.size()), 64'(1));
    if (got.size() == 1) begin
      checkOutput("post_rst_data", 64'(got[0].data), 64'(32'h7777_0003));
      checkOutput("post_rst_last", 64'(got[0].last), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
